// File: rtl/cmp_pkg.sv
// Purpose: shared types and flag-decoding helpers for the comparator result filter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: cls_t class encoding, debounce run-counter width, flag legality/decoding.
package cmp_pkg;

    typedef enum logic [1:0] {
        CLS_UNK = 2'd0,
        CLS_LT  = 2'd1,
        CLS_EQ  = 2'd2,
        CLS_GT  = 2'd3
    } cls_t;

    // Run counter width; holds DEB_LEN up to 15.
    localparam int RUN_W = 4;

    // Legal: exactly one of gt/eq/lt, and eq must come with ae.
    // Odd parity excluding the all-ones case gives "exactly one of three".
    function automatic logic flags_legal(input logic gt, input logic eq,
                                         input logic ae, input logic lt);
        return ((gt ^ eq ^ lt) & ~(gt & eq & lt)) & (~eq | ae);
    endfunction

    function automatic cls_t flags_to_cls(input logic gt, input logic eq, input logic lt);
        if (gt)      return CLS_GT;
        else if (eq) return CLS_EQ;
        else if (lt) return CLS_LT;
        else         return CLS_UNK;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Purpose: up-counter that saturates at all-ones, with synchronous clear.
// Latency: count visible one cycle after inc.
// Backpressure: none; inc is a single-cycle strobe.
// Ports: clk, rst (sync active-high), inc, clr (wins over inc), cnt.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cmp_result_filter.sv
// Purpose: debounce comparator flags into a stable class, count flags, emit change events.
// Latency: event visible one cycle after the accept that completes the debounce run.
// Backpressure: in_ready drops while an event is pending and the consumer is not taking it.
// Ports: clk, rst (sync active-high); in_valid/in_ready + gt/eq/ae/lt sample input;
//        clr_cnt; stable_cls; evt_valid/evt_ready + evt_old/evt_new/evt_ae;
//        gt_cnt/eq_cnt/ae_cnt/lt_cnt; sticky err.
module cmp_result_filter
    import cmp_pkg::*;
#(
    parameter int DEB_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             gt,
    input  logic             eq,
    input  logic             ae,
    input  logic             lt,
    input  logic             clr_cnt,
    output logic [1:0]       stable_cls,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_old,
    output logic [1:0]       evt_new,
    output logic             evt_ae,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] ae_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic             err
);

    localparam logic [RUN_W-1:0] DEB_MAX = RUN_W'(DEB_LEN);

    // Classifier
    logic acc;
    logic legal;
    cls_t smp_cls;

    // One-entry event buffer: room when empty or being drained this cycle.
    assign in_ready = !evt_valid || evt_ready;
    assign acc      = in_valid && in_ready;
    assign legal    = flags_legal(gt, eq, ae, lt);
    assign smp_cls  = flags_to_cls(gt, eq, lt);

    // Debounce state
    cls_t             cand_q, cand_d;
    cls_t             stab_q, stab_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             load;

    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q <= CLS_UNK;
            stab_q <= CLS_UNK;
            run_q  <= '0;
        end else begin
            cand_q <= cand_d;
            stab_q <= stab_d;
            run_q  <= run_d;
        end
    end

    always_comb begin
        cand_d = cand_q;
        stab_d = stab_q;
        run_d  = run_q;
        load   = 1'b0;
        if (acc) begin
            if (!legal) begin
                // An illegal sample breaks any run in progress.
                cand_d = CLS_UNK;
                run_d  = '0;
            end else begin
                if (smp_cls == cand_q) begin
                    run_d = (run_q == DEB_MAX) ? DEB_MAX : run_q + RUN_W'(1);
                end else begin
                    cand_d = smp_cls;
                    run_d  = RUN_W'(1);
                end
                if ((run_d == DEB_MAX) && (smp_cls != stab_q)) begin
                    stab_d = smp_cls;
                    load   = 1'b1;
                end
            end
        end
    end

    assign stable_cls = stab_q;

    // Event register. A load can only happen on an accept, which implies the
    // buffer is empty or being popped this edge, so nothing is ever lost.
    cls_t evt_old_q, evt_new_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_valid <= 1'b0;
            evt_old_q <= CLS_UNK;
            evt_new_q <= CLS_UNK;
            evt_ae    <= 1'b0;
        end else if (load) begin
            evt_valid <= 1'b1;
            evt_old_q <= stab_q;
            evt_new_q <= smp_cls;
            evt_ae    <= ae;
        end else if (evt_valid && evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

    assign evt_old = evt_old_q;
    assign evt_new = evt_new_q;

    // Sticky error; clr_cnt clears it even against a simultaneous illegal sample.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            err <= 1'b0;
        end else if (acc && !legal) begin
            err <= 1'b1;
        end
    end

    // Flag counters
    sat_counter #(.CNT_W(CNT_W)) u_gt_cnt (
        .clk(clk), .rst(rst), .inc(acc && gt), .clr(clr_cnt), .cnt(gt_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
        .clk(clk), .rst(rst), .inc(acc && eq), .clr(clr_cnt), .cnt(eq_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_ae_cnt (
        .clk(clk), .rst(rst), .inc(acc && ae), .clr(clr_cnt), .cnt(ae_cnt)
    );
    sat_counter #(.CNT_W(CNT_W)) u_lt_cnt (
        .clk(clk), .rst(rst), .inc(acc && lt), .clr(clr_cnt), .cnt(lt_cnt)
    );

endmodule

// File: tb/tb_cmp_result_filter.sv
// Purpose: self-checking bench for cmp_result_filter (8-bit and 2-bit counter builds).
// Latency: n/a.
// Backpressure: evt_ready driven by the scenarios and randomly.
module tb_cmp_result_filter;

    localparam int DEB = 3;

    logic clk = 1'b0;
    logic rst, in_valid, gt, eq, ae, lt, clr_cnt, evt_ready;

    logic       rdy8, ev8, ae8, err8;
    logic [1:0] stab8, old8, new8;
    logic [7:0] gtc8, eqc8, aec8, ltc8;
    logic       rdy2, ev2, ae2, err2;
    logic [1:0] stab2, old2, new2;
    logic [1:0] gtc2, eqc2, aec2, ltc2;

    always #5 clk = ~clk;

    cmp_result_filter #(.DEB_LEN(DEB), .CNT_W(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
        .gt(gt), .eq(eq), .ae(ae), .lt(lt), .clr_cnt(clr_cnt),
        .stable_cls(stab8), .evt_valid(ev8), .evt_ready(evt_ready),
        .evt_old(old8), .evt_new(new8), .evt_ae(ae8),
        .gt_cnt(gtc8), .eq_cnt(eqc8), .ae_cnt(aec8), .lt_cnt(ltc8), .err(err8)
    );

    cmp_result_filter #(.DEB_LEN(DEB), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
        .gt(gt), .eq(eq), .ae(ae), .lt(lt), .clr_cnt(clr_cnt),
        .stable_cls(stab2), .evt_valid(ev2), .evt_ready(evt_ready),
        .evt_old(old2), .evt_new(new2), .evt_ae(ae2),
        .gt_cnt(gtc2), .eq_cnt(eqc2), .ae_cnt(aec2), .lt_cnt(ltc2), .err(err2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: history of recent legal classes, event slot, counters.
    int   m_hist[$];
    int   m_stab, m_old, m_new;
    logic m_ev, m_ae, m_err, m_pre_rdy;
    int   m_cnt8[4];
    int   m_cnt2[4];
    logic pre_rdy8, pre_rdy2;

    function automatic logic [40:0] exp8();
        return {2'(m_stab), m_ev, 2'(m_old), 2'(m_new), m_ae, m_err,
                8'(m_cnt8[0]), 8'(m_cnt8[1]), 8'(m_cnt8[2]), 8'(m_cnt8[3])};
    endfunction

    function automatic logic [16:0] exp2();
        return {2'(m_stab), m_ev, 2'(m_old), 2'(m_new), m_ae, m_err,
                2'(m_cnt2[0]), 2'(m_cnt2[1]), 2'(m_cnt2[2]), 2'(m_cnt2[3])};
    endfunction

    // One clock: drive inputs, record pre-edge in_ready, advance model, step to next negedge.
    task automatic step(input logic iv, input logic g, input logic e, input logic a,
                        input logic l, input logic er, input logic cl, input logic r);
        logic acc, legal, load, f;
        int   c;
        in_valid = iv; gt = g; eq = e; ae = a; lt = l;
        evt_ready = er; clr_cnt = cl; rst = r;
        #1;
        pre_rdy8  = rdy8;
        pre_rdy2  = rdy2;
        m_pre_rdy = !m_ev || er;
        acc   = iv && m_pre_rdy;
        legal = (int'(g) + int'(e) + int'(l) == 1) && !(e && !a);
        c     = g ? 3 : (e ? 2 : 1);
        load  = 1'b0;
        if (r) begin
            m_hist.delete();
            m_stab = 0; m_old = 0; m_new = 0;
            m_ev = 1'b0; m_ae = 1'b0; m_err = 1'b0;
            for (int k = 0; k < 4; k++) begin m_cnt8[k] = 0; m_cnt2[k] = 0; end
        end else begin
            if (acc) begin
                if (legal) begin
                    m_hist.push_back(c);
                    if (m_hist.size() > DEB) void'(m_hist.pop_front());
                    if (m_hist.size() == DEB && c != m_stab) begin
                        load = 1'b1;
                        foreach (m_hist[i]) if (m_hist[i] != c) load = 1'b0;
                    end
                end else begin
                    m_hist.delete();
                end
            end
            for (int k = 0; k < 4; k++) begin
                f = (k == 0) ? g : (k == 1) ? e : (k == 2) ? a : l;
                if (cl) begin
                    m_cnt8[k] = 0; m_cnt2[k] = 0;
                end else if (acc && f) begin
                    if (m_cnt8[k] < 255) m_cnt8[k]++;
                    if (m_cnt2[k] < 3)   m_cnt2[k]++;
                end
            end
            if (cl) m_err = 1'b0;
            else if (acc && !legal) m_err = 1'b1;
            if (load) begin
                m_ev = 1'b1; m_old = m_stab; m_new = c; m_ae = a; m_stab = c;
            end else if (m_ev && er) begin
                m_ev = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({stab8, ev8, old8, new8, ae8, err8, gtc8, eqc8, aec8, ltc8} !== 41'd0) begin
            failures++;
            $display("FAIL reset_u8 got=%h exp=0",
                     {stab8, ev8, old8, new8, ae8, err8, gtc8, eqc8, aec8, ltc8});
        end
        checks++;
        if ({stab2, ev2, err2, gtc2, eqc2, aec2, ltc2} !== 12'd0) begin
            failures++;
            $display("FAIL reset_u2 got=%h exp=0", {stab2, ev2, err2, gtc2, eqc2, aec2, ltc2});
        end
        checks++;
        if (pre_rdy8 !== 1'b1 || rdy2 !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b%b exp=11", pre_rdy8, rdy2);
        end
    endtask

    task automatic test_gt_event();
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0, 0, 0, 0);
            checks++;
            if (ev8 !== (i == 2)) begin
                failures++;
                $display("FAIL gt_evt_timing sample=%0d got=%b exp=%b", i, ev8, (i == 2));
            end
        end
        checks++;
        if ({old8, new8, ae8, stab8, gtc8} !== {2'd0, 2'd3, 1'b0, 2'd3, 8'd3}) begin
            failures++;
            $display("FAIL gt_evt_fields got=%h exp=%h", {old8, new8, ae8, stab8, gtc8},
                     {2'd0, 2'd3, 1'b0, 2'd3, 8'd3});
        end
        step(0, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (ev8 !== 1'b0) begin
            failures++;
            $display("FAIL gt_evt_pop got=%b exp=0", ev8);
        end
    endtask

    task automatic test_lt_sequence();
        logic [5:0] seq_lt = 6'b111011;   // bit i: sample i is LT, else GT
        for (int i = 0; i < 6; i++) begin
            step(1, !seq_lt[i], 0, 0, seq_lt[i], 0, 0, 0);
            checks++;
            if (ev8 !== (i == 5) || ev8 !== m_ev) begin
                failures++;
                $display("FAIL lt_seq_timing sample=%0d got=%b exp=%b", i, ev8, (i == 5));
            end
        end
        checks++;
        if ({old8, new8, stab8, ltc8} !== {2'd3, 2'd1, 2'd1, 8'd5} || ltc2 !== 2'd3) begin
            failures++;
            $display("FAIL lt_seq_fields got=%h/%h exp=%h/3", {old8, new8, stab8, ltc8}, ltc2,
                     {2'd3, 2'd1, 2'd1, 8'd5});
        end
    endtask

    task automatic test_backpressure();
        logic [40:0] held = exp8();
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0, 0, 0, 0);
            checks++;
            if (pre_rdy8 !== 1'b0 || pre_rdy2 !== 1'b0) begin
                failures++;
                $display("FAIL bp_in_ready cyc=%0d got=%b%b exp=00", i, pre_rdy8, pre_rdy2);
            end
            checks++;
            if ({stab8, ev8, old8, new8, ae8, err8, gtc8, eqc8, aec8, ltc8} !== held) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=%h exp=%h", i,
                         {stab8, ev8, old8, new8, ae8, err8, gtc8, eqc8, aec8, ltc8}, held);
            end
        end
        step(0, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (ev8 !== 1'b0 || ev2 !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got=%b%b exp=00", ev8, ev2);
        end
    endtask

    task automatic test_illegal_clear();
        step(1, 1, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 1, 1, 0, 0);   // illegal gt+lt
        checks++;
        if (err8 !== 1'b1 || err2 !== 1'b1) begin
            failures++;
            $display("FAIL illegal_err got=%b%b exp=11", err8, err2);
        end
        step(1, 1, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 1, 0, 0);
        checks++;
        if (ev8 !== 1'b0 || stab8 !== 2'd1) begin
            failures++;
            $display("FAIL illegal_run_reset got=ev%b cls%0d exp=ev0 cls1", ev8, stab8);
        end
        step(1, 1, 0, 0, 0, 1, 0, 0);
        checks++;
        if ({ev8, old8, new8} !== {1'b1, 2'd1, 2'd3}) begin
            failures++;
            $display("FAIL illegal_recover got=%h exp=%h", {ev8, old8, new8}, {1'b1, 2'd1, 2'd3});
        end
        step(0, 0, 0, 0, 0, 1, 1, 0);
        checks++;
        if ({err8, gtc8, eqc8, aec8, ltc8, err2, gtc2, ltc2} !== 38'd0) begin
            failures++;
            $display("FAIL clr_cnt got=%h exp=0", {err8, gtc8, eqc8, aec8, ltc8, err2, gtc2, ltc2});
        end
        step(1, 1, 0, 1, 0, 1, 1, 0);
        checks++;
        if (gtc8 !== 8'd0 || aec8 !== 8'd0) begin
            failures++;
            $display("FAIL clr_wins got=%0d/%0d exp=0/0", gtc8, aec8);
        end
    endtask

    task automatic test_sat_eq();
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 1, 0, 1, 0, 0);
            if (i == 2) begin
                checks++;
                if ({ev2, old2, new2, ae2} !== {1'b1, 2'd3, 2'd2, 1'b1}) begin
                    failures++;
                    $display("FAIL sat_eq_evt got=%h exp=%h", {ev2, old2, new2, ae2},
                             {1'b1, 2'd3, 2'd2, 1'b1});
                end
            end
        end
        checks++;
        if ({eqc2, aec2, eqc8, aec8} !== {2'd3, 2'd3, 8'd5, 8'd5}) begin
            failures++;
            $display("FAIL sat_eq_cnt got=%h exp=%h", {eqc2, aec2, eqc8, aec8},
                     {2'd3, 2'd3, 8'd5, 8'd5});
        end
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({ev8, stab8, ev2, stab2} !== 6'd0) begin
            failures++;
            $display("FAIL rst_mid got=%h exp=0", {ev8, stab8, ev2, stab2});
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0, 0, 0, 0);
            checks++;
            if (ev8 !== (i == 2) || stab8 !== ((i == 2) ? 2'd3 : 2'd0)) begin
                failures++;
                $display("FAIL rst_fresh_deb sample=%0d got=ev%b cls%0d", i, ev8, stab8);
            end
        end
        step(0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_random();
        logic iv, g, e, a, l, er, cl, r;
        int   sel;
        for (int n = 0; n < 800; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 8) begin
                sel = int'($urandom_range(1, 3));
                g = (sel == 3); e = (sel == 2); l = (sel == 1);
                a = e ? 1'b1 : 1'(($urandom_range(0, 3) == 0));
                // Long same-class runs so debounce events actually occur.
                if ($urandom_range(0, 1) == 1 && m_hist.size() > 0) begin
                    sel = m_hist[$];
                    g = (sel == 3); e = (sel == 2); l = (sel == 1);
                    a = e ? 1'b1 : a;
                end
            end else begin
                {g, e, a, l} = 4'($urandom_range(0, 15));
            end
            iv = ($urandom_range(0, 3) != 0);
            er = ($urandom_range(0, 2) != 0);
            cl = ($urandom_range(0, 40) == 0);
            r  = ($urandom_range(0, 150) == 0);
            step(iv, g, e, a, l, er, cl, r);
            checks++;
            if (pre_rdy8 !== m_pre_rdy || pre_rdy2 !== m_pre_rdy) begin
                failures++;
                $display("FAIL rand_in_ready n=%0d got=%b%b exp=%b", n, pre_rdy8, pre_rdy2, m_pre_rdy);
            end
            checks++;
            if ({stab8, ev8, old8, new8, ae8, err8, gtc8, eqc8, aec8, ltc8} !== exp8()) begin
                failures++;
                $display("FAIL rand_u8 n=%0d got=%h exp=%h", n,
                         {stab8, ev8, old8, new8, ae8, err8, gtc8, eqc8, aec8, ltc8}, exp8());
            end
            checks++;
            if ({stab2, ev2, old2, new2, ae2, err2, gtc2, eqc2, aec2, ltc2} !== exp2()) begin
                failures++;
                $display("FAIL rand_u2 n=%0d got=%h exp=%h", n,
                         {stab2, ev2, old2, new2, ae2, err2, gtc2, eqc2, aec2, ltc2}, exp2());
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; gt = 1'b0; eq = 1'b0; ae = 1'b0; lt = 1'b0;
        clr_cnt = 1'b0; evt_ready = 1'b0;
        m_stab = 0; m_old = 0; m_new = 0; m_ev = 1'b0; m_ae = 1'b0; m_err = 1'b0;
        m_pre_rdy = 1'b1; pre_rdy8 = 1'b0; pre_rdy2 = 1'b0;
        for (int k = 0; k < 4; k++) begin m_cnt8[k] = 0; m_cnt2[k] = 0; end
        @(negedge clk);
        test_reset();
        test_gt_event();
        test_lt_sequence();
        test_backpressure();
        test_illegal_clear();
        test_sat_eq();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
